axi_wr_flood_limiter: RTL
=========================

Name: axi_wr_flood_limiter

Overview:
- Per-master AXI4 write-channel regulator placed between one master port (victim or attacker VIP) and its slave port on the shared interconnect.
- Caps outstanding writes (AW accepted, B not yet returned) and enforces a per-window beat budget (token bucket).
- Reports throttle state and a sticky flood flag, so write-flood DoS traffic is contained before it reaches the shared memory.

Parameters:
- ADDR_W, 32, AW address width
- DATA_W, 32, W data width (strobe width DATA_W/8)
- ID_W, 4, AXI ID width
- MAX_OUTSTANDING, 4, max AW accepted without matching B (1..255)
- BEAT_BUDGET, 512, beats allowed per window (must be >= 256)
- WINDOW_CYCLES, 4096, window length in clocks (>= 2)
- FLOOD_THRESH, 64, consecutive blocked-AW cycles that set flood_flag

Ports:
- clk_100MHz in 1 clock
- reset_rtl_0 in 1 asynchronous active-low reset
- s_aw{id,addr,len,size,burst} in ID_W/ADDR_W/8/3/2; s_awvalid in 1; s_awready out 1 — upstream AW
- m_aw{id,addr,len,size,burst} out (same widths); m_awvalid out 1; m_awready in 1 — downstream AW
- s_wdata/s_wstrb/s_wlast/s_wvalid in DATA_W/DATA_W/8/1/1; s_wready out 1 — upstream W
- m_wdata/m_wstrb/m_wlast/m_wvalid out; m_wready in 1 — downstream W
- m_bid/m_bresp/m_bvalid in ID_W/2/1; m_bready out 1 — downstream B
- s_bid/s_bresp/s_bvalid out; s_bready in 1 — upstream B
- clr_stats in 1 — pulse that clears the flood flag and throttle count
- throttle_state out 2 — 0 OPEN, 1 LIMIT_OT, 2 LIMIT_BUDGET
- outstanding_cnt out 8 — current outstanding writes
- budget_left out 16 — beats remaining in the current window
- throttle_cycles out 32 — saturating count of blocked-AW cycles
- flood_flag out 1 — sticky flood indication

Behaviour:
- Datapath fields pass through combinationally; only valid/ready are gated. Zero added latency.
- allow = (outstanding_cnt < MAX_OUTSTANDING) && (budget_left >= s_awlen+1).
- AW gating:
  - m_awvalid = s_awvalid & allow
  - s_awready = m_awready & allow
  - allow only falls on an AW handshake, so an asserted m_awvalid is never withdrawn.
- W gating:
  - wpend counts accepted AW bursts whose WLAST has not yet passed.
  - m_wvalid = s_wvalid & (wpend != 0); s_wready = m_wready & (wpend != 0).
  - W beats are never forwarded ahead of their AW.
  - wpend: +1 on AW handshake, -1 on a W handshake with wlast; both in the same cycle leaves it unchanged.
- B is pure pass-through (s_b* = m_b*, m_bready = s_bready).
- outstanding_cnt: +1 on AW handshake, -1 on B handshake; both in the same cycle leaves it unchanged. Never underflows: a B handshake with count 0 is ignored.
- Token bucket:
  - The window counter counts 0..WINDOW_CYCLES-1 and wraps.
  - On the wrap cycle budget_left reloads to BEAT_BUDGET (no carry-over).
  - An AW handshake subtracts awlen+1.
  - A handshake in the wrap cycle gives budget_left = BEAT_BUDGET - (awlen+1).
- throttle_state is registered and updated every cycle:
  - LIMIT_OT if s_awvalid & outstanding limit hit.
  - Else LIMIT_BUDGET if s_awvalid & budget insufficient.
  - Else OPEN.
- throttle_cycles increments on each cycle with s_awvalid & !allow; saturates at 2^32-1.
- Flood detection:
  - A run counter tracks consecutive blocked cycles and resets on any cycle that is not blocked.
  - flood_flag sets when the run reaches FLOOD_THRESH and is sticky.
- clr_stats (synchronous) zeroes throttle_cycles, the run counter and flood_flag. If clr_stats coincides with a blocked cycle, the clear wins.
- Reset (async assert, sync deassert expected upstream):
  - outstanding_cnt=0, wpend=0, budget_left=BEAT_BUDGET, window=0, throttle_state=OPEN, throttle_cycles=0, flood_flag=0.
  - While reset_rtl_0 is low, all m_*valid and s_*ready are forced 0.
  - Reset mid-burst drops all tracking; the system must reset both sides together.

Decomposition:
- Package axi_wr_lim_pkg:
  - throttle_state_e enum (OPEN, LIMIT_OT, LIMIT_BUDGET)
  - width localparams (OT_W=8, BUD_W=16, STAT_W=32)
  - AXI burst/resp encodings
- Sub-module axi_wr_token_bucket: window counter, reload and consume logic; outputs budget_left and the sufficient-budget compare for a given awlen.

Test Plan:
- Reset, then one AW len=0 with m_awready=1, one W beat with wlast, then B OKAY → outstanding 0→1→0, budget_left 512→511, throttle_state OPEN.
- Six back-to-back AW len=0 with B withheld → four handshakes, 5th sees s_awready=0 and throttle_state=LIMIT_OT; release one B → 5th accepted the next cycle, outstanding stays 4.
- AW len=255 twice (512 beats) → budget_left=0; third AW blocked, throttle_state=LIMIT_BUDGET until window wrap at cycle 4095 → budget reloads to 512, AW accepted, budget_left=256.
- outstanding=2; AW handshake and B handshake in the same cycle → outstanding stays 2. W beat with wlast and new AW in the same cycle → wpend unchanged.
- W presented before AW → s_wready=0, m_wvalid=0 until the AW handshake, then 4 beats (len=3) pass; wpend returns to 0 after wlast.
- AW blocked 64 consecutive cycles → flood_flag=1 at the 64th blocked cycle, throttle_cycles=64; clr_stats pulse → both 0. Async reset asserted mid-burst → all counters reset and all valids/readies 0 immediately.

Source files
------------

// File: rtl/axi_wr_lim_pkg.sv
// Shared types, widths and AXI encodings for the AXI write-flood limiter.
package axi_wr_lim_pkg;

    localparam int unsigned OT_W    = 8;
    localparam int unsigned BUD_W   = 16;
    localparam int unsigned STAT_W  = 32;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned BEATS_W = LEN_W + 1;

    typedef enum logic [1:0] {
        OPEN         = 2'd0,
        LIMIT_OT     = 2'd1,
        LIMIT_BUDGET = 2'd2
    } throttle_state_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Beats in a burst: AxLEN + 1, widened so len=255 gives 256.
    function automatic logic [BEATS_W-1:0] burst_beats(input logic [LEN_W-1:0] len);
        return BEATS_W'(len) + BEATS_W'(1);
    endfunction

endpackage

// File: rtl/axi_wr_token_bucket.sv
// Per-window beat budget: free-running window counter, reload on wrap, consume on AW.
module axi_wr_token_bucket
    import axi_wr_lim_pkg::*;
#(
    parameter int unsigned BEAT_BUDGET   = 512,
    parameter int unsigned WINDOW_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             consume,
    input  logic [LEN_W-1:0] awlen,
    output logic [BUD_W-1:0] budget_left,
    output logic             budget_ok_c
);

    localparam int unsigned WIN_W = $clog2(WINDOW_CYCLES);
    localparam int unsigned CMP_W = BUD_W + 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [BUD_W-1:0] BUD_FULL = BUD_W'(BEAT_BUDGET);

    logic [WIN_W-1:0]   win_q;
    logic [BEATS_W-1:0] beats;
    logic [BUD_W-1:0]   base;
    logic [BUD_W-1:0]   budget_d;
    logic               wrap;

    // Wrap-cycle handshakes consume from the fresh budget, not the old one.
    always_comb begin
        beats       = burst_beats(awlen);
        wrap        = (win_q == WIN_LAST);
        budget_ok_c = (CMP_W'(budget_left) >= CMP_W'(beats));
        base        = wrap ? BUD_FULL : budget_left;
        budget_d    = consume ? (base - BUD_W'(beats)) : base;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q       <= '0;
            budget_left <= BUD_FULL;
        end else begin
            win_q       <= wrap ? '0 : (win_q + WIN_W'(1));
            budget_left <= budget_d;
        end
    end

endmodule

// File: rtl/axi_wr_flood_limiter.sv
// AXI4 write-channel regulator: caps outstanding writes and per-window beats,
// keeps W behind its AW, and flags sustained AW blocking as a flood.
module axi_wr_flood_limiter
    import axi_wr_lim_pkg::*;
#(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned ID_W            = 4,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned BEAT_BUDGET     = 512,
    parameter int unsigned WINDOW_CYCLES   = 4096,
    parameter int unsigned FLOOD_THRESH    = 64
) (
    input  logic                  clk_100MHz,
    input  logic                  reset_rtl_0,

    input  logic [ID_W-1:0]       s_awid,
    input  logic [ADDR_W-1:0]     s_awaddr,
    input  logic [7:0]            s_awlen,
    input  logic [2:0]            s_awsize,
    input  logic [1:0]            s_awburst,
    input  logic                  s_awvalid,
    output logic                  s_awready,

    output logic [ID_W-1:0]       m_awid,
    output logic [ADDR_W-1:0]     m_awaddr,
    output logic [7:0]            m_awlen,
    output logic [2:0]            m_awsize,
    output logic [1:0]            m_awburst,
    output logic                  m_awvalid,
    input  logic                  m_awready,

    input  logic [DATA_W-1:0]     s_wdata,
    input  logic [DATA_W/8-1:0]   s_wstrb,
    input  logic                  s_wlast,
    input  logic                  s_wvalid,
    output logic                  s_wready,

    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    output logic                  m_wlast,
    output logic                  m_wvalid,
    input  logic                  m_wready,

    input  logic [ID_W-1:0]       m_bid,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,

    output logic [ID_W-1:0]       s_bid,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,

    input  logic                  clr_stats,
    output logic [1:0]            throttle_state,
    output logic [OT_W-1:0]       outstanding_cnt,
    output logic [BUD_W-1:0]      budget_left,
    output logic [STAT_W-1:0]     throttle_cycles,
    output logic                  flood_flag
);

    localparam int unsigned RUN_W = $clog2(FLOOD_THRESH + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FLOOD_THRESH);
    localparam logic [OT_W-1:0]  OT_MAX  = OT_W'(MAX_OUTSTANDING);

    logic              ot_full_c;
    logic              budget_ok_c;
    logic              allow_c;
    logic              w_open_c;
    logic              aw_hs_c;
    logic              wlast_hs_c;
    logic              b_hs_c;
    logic              blocked_c;

    logic [OT_W-1:0]   wpend_q;
    logic [OT_W-1:0]   wpend_d;
    logic [OT_W-1:0]   ot_d;
    throttle_state_e   state_q;
    throttle_state_e   state_d;
    logic [RUN_W-1:0]  run_q;
    logic [RUN_W-1:0]  run_d;
    logic [STAT_W-1:0] thr_d;
    logic              flood_d;

    assign m_awid    = s_awid;
    assign m_awaddr  = s_awaddr;
    assign m_awlen   = s_awlen;
    assign m_awsize  = s_awsize;
    assign m_awburst = s_awburst;
    assign m_wdata   = s_wdata;
    assign m_wstrb   = s_wstrb;
    assign m_wlast   = s_wlast;
    assign s_bid     = m_bid;
    assign s_bresp   = m_bresp;
    assign s_bvalid  = m_bvalid;
    assign m_bready  = s_bready;

    // Handshake gating; reset low forces every gated valid/ready to 0.
    assign ot_full_c  = (outstanding_cnt >= OT_MAX);
    assign allow_c    = !ot_full_c && budget_ok_c;
    assign m_awvalid  = reset_rtl_0 & s_awvalid & allow_c;
    assign s_awready  = reset_rtl_0 & m_awready & allow_c;
    assign w_open_c   = reset_rtl_0 & (wpend_q != '0);
    assign m_wvalid   = s_wvalid & w_open_c;
    assign s_wready   = m_wready & w_open_c;

    assign aw_hs_c    = s_awvalid & s_awready;
    assign wlast_hs_c = s_wvalid & s_wready & s_wlast;
    assign b_hs_c     = m_bvalid & s_bready & (outstanding_cnt != '0);
    assign blocked_c  = s_awvalid & ~allow_c;
    assign throttle_state = state_q;

    axi_wr_token_bucket #(
        .BEAT_BUDGET   (BEAT_BUDGET),
        .WINDOW_CYCLES (WINDOW_CYCLES)
    ) u_bucket (
        .clk         (clk_100MHz),
        .rst_n       (reset_rtl_0),
        .consume     (aw_hs_c),
        .awlen       (s_awlen),
        .budget_left (budget_left),
        .budget_ok_c (budget_ok_c)
    );

    always_comb begin
        ot_d    = outstanding_cnt;
        wpend_d = wpend_q;
        state_d = OPEN;
        thr_d   = throttle_cycles;
        run_d   = run_q;
        flood_d = flood_flag;

        case ({aw_hs_c, b_hs_c})
            2'b10:   ot_d = outstanding_cnt + OT_W'(1);
            2'b01:   ot_d = outstanding_cnt - OT_W'(1);
            default: ot_d = outstanding_cnt;
        endcase

        case ({aw_hs_c, wlast_hs_c})
            2'b10:   wpend_d = wpend_q + OT_W'(1);
            2'b01:   wpend_d = wpend_q - OT_W'(1);
            default: wpend_d = wpend_q;
        endcase

        if (s_awvalid && ot_full_c) begin
            state_d = LIMIT_OT;
        end else if (s_awvalid && !budget_ok_c) begin
            state_d = LIMIT_BUDGET;
        end

        // Clear beats a coincident blocked cycle.
        if (clr_stats) begin
            thr_d   = '0;
            run_d   = '0;
            flood_d = 1'b0;
        end else if (blocked_c) begin
            if (throttle_cycles != '1) begin
                thr_d = throttle_cycles + STAT_W'(1);
            end
            if (run_q != RUN_MAX) begin
                run_d = run_q + RUN_W'(1);
            end
            if (run_d >= RUN_MAX) begin
                flood_d = 1'b1;
            end
        end else begin
            run_d = '0;
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            outstanding_cnt <= '0;
            wpend_q         <= '0;
            state_q         <= OPEN;
            throttle_cycles <= '0;
            run_q           <= '0;
            flood_flag      <= 1'b0;
        end else begin
            outstanding_cnt <= ot_d;
            wpend_q         <= wpend_d;
            state_q         <= state_d;
            throttle_cycles <= thr_d;
            run_q           <= run_d;
            flood_flag      <= flood_d;
        end
    end

endmodule
